// File: rtl/line_clear.sv
// Row-clear engine: removes full rows from a locked playfield one row per clock,
// compacts the survivors downward, zero-fills the top and keeps a saturating score.
module line_clear #(
    parameter int unsigned ROWS    = 20,
    parameter int unsigned COLS    = 10,
    parameter int unsigned SCORE_W = 20
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [ROWS-1:0][COLS-1:0]        screen_in,
    output logic                             busy,
    output logic                             done,
    output logic [ROWS-1:0][COLS-1:0]        screen_out,
    output logic [$clog2(ROWS+1)-1:0]        lines_cleared,
    output logic [SCORE_W-1:0]               score
);

    localparam int unsigned PW = $clog2(ROWS + 1);

    typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_t;

    state_t                      state;
    logic [ROWS-1:0][COLS-1:0]   work;
    logic [PW-1:0]               rd;
    logic [PW-1:0]               wr;
    logic [PW-1:0]               k;

    logic [SCORE_W:0]            pts_c;
    logic [SCORE_W:0]            sum_c;
    logic [SCORE_W-1:0]          score_nxt_c;
    logic                        row_full_c;
    logic [PW-1:0]               k_inc_c;

    // Points for the current clear count, then a one-bit-wider add that saturates.
    always_comb begin
        pts_c = '0;
        case (k)
            PW'(0):  pts_c = '0;
            PW'(1):  pts_c = (SCORE_W+1)'(40);
            PW'(2):  pts_c = (SCORE_W+1)'(100);
            PW'(3):  pts_c = (SCORE_W+1)'(300);
            default: pts_c = (SCORE_W+1)'(1200);
        endcase
        sum_c       = {1'b0, score} + pts_c;
        score_nxt_c = sum_c[SCORE_W] ? {SCORE_W{1'b1}} : sum_c[SCORE_W-1:0];
        row_full_c  = &work[rd];
        k_inc_c     = row_full_c ? k + PW'(1) : k;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            screen_out    <= '0;
            lines_cleared <= '0;
            score         <= '0;
            work          <= '0;
            rd            <= '0;
            wr            <= '0;
            k             <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work  <= screen_in;
                        rd    <= '0;
                        wr    <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (row_full_c) begin
                        k <= k_inc_c;
                    end else begin
                        work[wr] <= work[rd];
                        wr       <= wr + PW'(1);
                    end
                    rd <= rd + PW'(1);
                    if (rd == PW'(ROWS - 1)) begin
                        if (k_inc_c != '0) begin
                            state <= FILL;
                        end else begin
                            // Nothing removed: every copy was in place, work is final.
                            screen_out    <= work;
                            lines_cleared <= '0;
                            done          <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                FILL: begin
                    work[wr] <= '0;
                    wr       <= wr + PW'(1);
                    if (wr == PW'(ROWS - 1)) begin
                        // Top row is zeroed on this same edge, so fold it into the result.
                        screen_out    <= {{COLS{1'b0}}, work[ROWS-2:0]};
                        lines_cleared <= k;
                        score         <= score_nxt_c;
                        done          <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear.sv
// Self-checking bench for line_clear: directed cases, randomized playfields and
// score saturation, compared against a row-filtering reference model.
module tb_line_clear;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int SW   = 20;
    localparam int SMAX = (1 << SW) - 1;

    typedef logic [ROWS-1:0][COLS-1:0] pf_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    pf_t                  screen_in;
    logic                 busy;
    logic                 done;
    pf_t                  screen_out;
    logic [4:0]           lines_cleared;
    logic [SW-1:0]        score;

    int vectors    = 0;
    int miscompares = 0;
    int mscore     = 0;

    line_clear #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(SW)) dut (
        .clk(clk), .reset(reset), .start(start), .screen_in(screen_in),
        .busy(busy), .done(done), .screen_out(screen_out),
        .lines_cleared(lines_cleared), .score(score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: keep non-full rows in bottom-up order, pad the top with zeros.
    function automatic void ref_clear(input pf_t s, output pf_t o, output int k);
        logic [COLS-1:0] kept[$];
        kept = {};
        for (int r = 0; r < ROWS; r++)
            if (s[r] != {COLS{1'b1}}) kept.push_back(s[r]);
        o = '0;
        foreach (kept[i]) o[i] = kept[i];
        k = ROWS - kept.size();
    endfunction

    function automatic int pts(input int k);
        case (k)
            0: return 0;
            1: return 40;
            2: return 100;
            3: return 300;
            default: return 1200;
        endcase
    endfunction

    // One operation: start, optional stray start while busy, wait for done, check all.
    task automatic run_op(input string tag, input pf_t scr, input bit inject, input pf_t alt);
        pf_t exp_pf;
        int  exp_k;
        int  cyc;
        bit  got;
        ref_clear(scr, exp_pf, exp_k);
        mscore = (mscore + pts(exp_k) > SMAX) ? SMAX : mscore + pts(exp_k);
        @(negedge clk);
        screen_in = scr;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        screen_in = ~scr;
        chk({tag, ".busy_after_start"}, 256'(busy), 256'(1));
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 100) begin
            if (inject && cyc == 2) begin
                screen_in = alt;
                start     = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            got = done;
        end
        chk({tag, ".done_seen"}, 256'(got), 256'(1));
        chk({tag, ".latency"}, 256'(cyc), 256'(ROWS + exp_k));
        chk({tag, ".busy_in_done"}, 256'(busy), 256'(1));
        chk({tag, ".screen_out"}, 256'(screen_out), 256'(exp_pf));
        chk({tag, ".lines"}, 256'(lines_cleared), 256'(exp_k));
        chk({tag, ".score"}, 256'(score), 256'(mscore));
        @(posedge clk); #1;
        chk({tag, ".done_pulse_len"}, 256'(done), 256'(0));
        chk({tag, ".idle_busy"}, 256'(busy), 256'(0));
    endtask

    task automatic run_quiet(input pf_t scr);
        pf_t exp_pf;
        int  exp_k;
        int  cyc;
        ref_clear(scr, exp_pf, exp_k);
        mscore = (mscore + pts(exp_k) > SMAX) ? SMAX : mscore + pts(exp_k);
        @(negedge clk);
        screen_in = scr;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $error("FAIL preload.timeout observed=%0d expected=%0d", cyc, ROWS + exp_k);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        pf_t s, alt, four;
        int  cyc;
        bit  seen;
        reset     = 1'b1;
        start     = 1'b1;
        screen_in = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", 256'(busy), 256'(0));
        chk("reset.done", 256'(done), 256'(0));
        chk("reset.screen_out", 256'(screen_out), 256'(0));
        chk("reset.lines", 256'(lines_cleared), 256'(0));
        chk("reset.score", 256'(score), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;

        s = '0;
        run_op("empty", s, 1'b0, s);

        s = '0;
        for (int r = 0; r < 4; r++) s[r] = 10'h3FF;
        s[4] = 10'h201;
        four = s;
        run_op("four_lines", s, 1'b0, s);
        chk("four_lines.row0", 256'(screen_out[0]), 256'(10'h201));
        chk("four_lines.score_abs", 256'(score), 256'(1200));

        s = '0;
        s[0] = 10'h001; s[1] = 10'h3FF; s[2] = 10'h002; s[3] = 10'h3FF; s[5] = 10'h100;
        run_op("two_lines", s, 1'b0, s);
        chk("two_lines.row3", 256'(screen_out[3]), 256'(10'h100));
        chk("two_lines.score_abs", 256'(score), 256'(1300));

        s = '0;
        s[0] = 10'h3FF; s[7] = 10'h155;
        alt = '1;
        run_op("ignored_start", s, 1'b1, alt);

        // Abort mid-scan: reset must clear everything and no done may follow.
        @(negedge clk);
        screen_in = four;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        mscore = 0;
        chk("abort.busy", 256'(busy), 256'(0));
        chk("abort.screen_out", 256'(screen_out), 256'(0));
        chk("abort.score", 256'(score), 256'(0));
        chk("abort.lines", 256'(lines_cleared), 256'(0));
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk("abort.no_done", 256'(seen), 256'(0));
        s = '0;
        s[0] = 10'h3FF; s[1] = 10'h0F0;
        run_op("after_abort", s, 1'b0, s);

        for (int t = 0; t < 40; t++) begin
            s = '0;
            for (int r = 0; r < ROWS; r++) begin
                case ($urandom_range(0, 3))
                    0: s[r] = 10'h3FF;
                    1: s[r] = '0;
                    default: s[r] = 10'($urandom);
                endcase
            end
            run_op($sformatf("rand%0d", t), s, 1'(t % 5 == 0), ~s);
        end

        // Drive the score near the top, then one more 4-line clear must saturate.
        cyc = 0;
        while (mscore < SMAX + 1 - 1200 && cyc < 1000) begin
            run_quiet(four);
            cyc++;
        end
        chk("preload.score", 256'(score), 256'(mscore));
        run_op("saturate", four, 1'b0, four);
        chk("saturate.max", 256'(score), 256'(20'hFFFFF));
        run_op("saturate_hold", four, 1'b0, four);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/line_clear.md
Name: line_clear

Overview:
- Downstream of the move stage (down/left/right shifters). When a falling piece can no longer move down, the game controller pulses `start` with the locked 20x10 playfield.
- The block scans the playfield, removes every full row and compacts the rows above downward (row 0 = bottom). It fills the vacated top rows with zeros, then presents the cleaned playfield, the number of rows cleared and a running score.
- Multi-cycle, one row per clock, so no wide combinational compaction network is needed.

Parameters:
- ROWS, 20, playfield rows (row 0 = bottom, matches shapeRowPos convention).
- COLS, 10, playfield columns.
- SCORE_W, 20, width of the score accumulator.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; playfield on screen_in is locked and ready.
- screen_in  in  [ROWS-1:0][COLS-1:0]  locked playfield, sampled only on the accepted start edge.
- busy  out  1  high in SCAN, FILL and DONE states.
- done  out  1  one-cycle pulse; screen_out, lines_cleared and score are valid/updated.
- screen_out  out  [ROWS-1:0][COLS-1:0]  compacted playfield; holds until next done.
- lines_cleared  out  $clog2(ROWS+1)  full rows removed by the last operation.
- score  out  SCORE_W  accumulated score, saturating.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk and reset).
- Reset values (synchronous, any state):
  - state=IDLE; busy=0, done=0.
  - screen_out=0, lines_cleared=0, score=0.
  - Work buffer, read pointer rd, write pointer wr and count k all cleared.
- Reset mid-operation aborts the scan; no partial result is ever driven on screen_out.
- States: IDLE, SCAN, FILL, DONE.
- IDLE:
  - start=1 latches screen_in into the work buffer and sets rd=0, wr=0, k=0; next state SCAN.
  - start=0 stays in IDLE.
- SCAN, one edge per row, rd = 0..ROWS-1:
  - Row buf[rd] full (all COLS bits 1): k<=k+1; wr unchanged; row dropped.
  - Otherwise: buf[wr]<=buf[rd]; wr<=wr+1. In-place copy is safe since wr<=rd; wr==rd is a no-op.
  - rd<=rd+1.
  - After the rd=ROWS-1 edge: next state FILL if k>0, else DONE.
  - A row containing any 0 bit is never removed; an all-zero row is kept, not cleared.
- FILL:
  - Each edge writes buf[wr]<=0 and wr<=wr+1.
  - Leave to DONE on the edge where wr reaches ROWS-1, so exactly k edges are spent in FILL.
- DONE transition (edge entering DONE):
  - screen_out<=buf, lines_cleared<=k.
  - score<=min(score+pts(k), 2^SCORE_W-1).
  - pts: 0→0, 1→40, 2→100, 3→300, ≥4→1200.
  - Add at SCORE_W+1 bits, then saturate.
- DONE: done=1 for exactly one cycle; next state IDLE.
- Latency: done is high in the cycle following edge (ROWS+k) after the start-sampling edge, i.e. 20+k cycles for defaults.
- start while busy (SCAN/FILL/DONE) is ignored: no restart, no queueing.
- start in the same cycle as reset: reset wins.
- screen_in changes after acceptance have no effect.
- Back-to-back: start may be accepted in the IDLE cycle immediately after DONE.
- Outputs other than done/busy change only on the DONE-entry edge or reset.

Test Plan:
- Empty playfield, start → done 20 cycles after the start edge; screen_out=0, lines_cleared=0, score=0.
- Rows 0–3 = 10'h3FF, row 4 = 10'h201, rest 0 → done at +24; screen_out row0=10'h201, rows1–19=0; lines_cleared=4; score=1200.
- Rows 1 and 3 full; row 0=10'h001, row 2=10'h002, row 5=10'h100 → done at +22; rows0..3 = 001,002,000,100 (hex); lines_cleared=2; score +100.
- Pulse start again 3 cycles after the first accepted start with a different screen_in → ignored; result matches the first playfield only; single done pulse.
- Assert reset 10 cycles into SCAN → next cycle busy=0, screen_out=0, score=0; no done pulse; a new start then completes normally.
- Preload score near saturation (≥ 2^20−1200 via repeated 4-line clears), then clear 4 rows → score=20'hFFFFF, no wrap.
